// File: rtl/aes_key_expander.sv
// ----------------------------------------------------------------------------
// aes_key_expander
//
// Sequential AES-128 key schedule. A 128-bit cipher key is accepted over a
// valid/ready handshake, then one keygen round is evaluated per clock
// (round 1..10) and each result is written into an 11-entry round-key file
// (rk0..rk10). Round keys are served by index to the cipher datapath.
//
// Byte order: byte0 of a 128-bit word sits in bits [127:120]. This is the same
// numeric value as the FIPS-197 hex string, e.g. 128'h2b7e...3c has byte0 = 2b.
//
// Parameters:
//   RD_REG   1: rd_key registered (1-cycle read latency), 0: combinational
//   NROUNDS  number of expansion rounds; only 10 (AES-128) is legal
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   key_in      cipher key
//   key_valid   key_in valid
//   key_ready   a key can be accepted (idle or done)
//   busy        expansion in progress
//   keys_valid  rk0..rk10 complete and consistent
//   done        one-cycle pulse when rk10 is written
//   rd_idx      round-key index 0..10 (11..15 read as zero)
//   rd_key      selected round key
//
// Build option:
//   KEYEXP_INV_READ_EN  when defined, rd_idx i (0..10) returns rk[10-i] for
//                       decryption order; 11..15 still read as zero.
// ----------------------------------------------------------------------------
module aes_key_expander #(
    parameter int unsigned RD_REG  = 1,
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int unsigned NumKeys   = NROUNDS + 1;
    localparam logic [3:0]  LastRound = 4'(NROUNDS);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic and S-box (inverse computed as x^254, then affine)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);  // x^254 == x^-1, and 0 maps to 0
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant; counts outside 1..10 give zero.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic         keys_valid_q, keys_valid_d;
    logic         done_q, done_d;
    logic [127:0] rk_q [NumKeys];

    logic         rk_we;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;

    // ------------------------------------------------------------------
    // Single keygen round, purely combinational on work_q / cnt_q
    // ------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0]  rot_w, sub_w;
    logic [127:0] kg_out;

    always_comb begin
        w0    = work_q[127:96];
        w1    = work_q[95:64];
        w2    = work_q[63:32];
        w3    = work_q[31:0];
        rot_w = {w3[23:0], w3[31:24]};
        sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        w4    = w0 ^ sub_w ^ {rcon(cnt_q), 24'h000000};
        w5    = w1 ^ w4;
        w6    = w2 ^ w5;
        w7    = w3 ^ w6;
        kg_out = {w4, w5, w6, w7};
    end

    // ------------------------------------------------------------------
    // FSM next-state and round-key write port
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        rk_we        = 1'b0;
        rk_widx      = cnt_q;
        rk_wdata     = kg_out;
        case (state_q)
            StIdle, StDone: begin
                if (key_valid) begin
                    state_d      = StExpand;
                    work_d       = key_in;
                    cnt_d        = 4'd1;
                    keys_valid_d = 1'b0;
                    rk_we        = 1'b1;
                    rk_widx      = 4'd0;
                    rk_wdata     = key_in;
                end
            end
            StExpand: begin
                // key_valid is deliberately ignored here: no queueing, no abort.
                rk_we  = 1'b1;
                work_d = kg_out;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LastRound) begin
                    state_d      = StDone;
                    keys_valid_d = 1'b1;
                    done_d       = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            work_q       <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumKeys; i++) rk_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NumKeys; i++) begin
                if (rk_we && (rk_widx == 4'(i))) rk_q[i] <= rk_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic [3:0]   rd_eff;
    logic [127:0] rd_val;

    always_comb begin
`ifdef KEYEXP_INV_READ_EN
        // Indices 11..15 wrap to 15..11 and therefore match no entry below.
        rd_eff = LastRound - rd_idx;
`else
        rd_eff = rd_idx;
`endif
        rd_val = '0;
        for (int unsigned i = 0; i < NumKeys; i++) begin
            if (rd_eff == 4'(i)) rd_val = rk_q[i];
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [127:0] rd_key_q;
        // Samples the pre-edge file contents, so a same-edge write returns the old key.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_key_q <= '0;
            else        rd_key_q <= rd_val;
        end
        assign rd_key = rd_key_q;
    end else begin : g_rd_comb
        assign rd_key = rd_val;
    end

    assign key_ready  = (state_q != StExpand);
    assign busy       = (state_q == StExpand);
    assign keys_valid = keys_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: stimulus pushes expected read data and expected
// done-pulse cycles into queues; monitor processes pop and compare them.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready, busy, keys_valid, done;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;

    aes_key_expander #(.RD_REG(1), .NROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KeyZero = 128'h0;

    // FIPS-197 Appendix A.1 schedule.
    localparam logic [127:0] FipsRk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [127:0] rd_exp_q [$];
    string        rd_name_q [$];
    int           done_exp_q [$];
    logic         rd_req = 1'b0;
    logic         rd_seen = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= rd_req;
    end

    // Read monitor: a request sampled at a rising edge is visible on rd_key
    // after that edge.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", 128'd1, 128'd0);
            end else begin
                check(rd_name_q.pop_front(), rd_key, rd_exp_q.pop_front());
            end
        end
    end

    // Done monitor: every done pulse must be expected, land on the expected
    // cycle, and coincide with keys_valid.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (done_exp_q.size() == 0) begin
                check("done_unexpected", 128'd1, 128'd0);
            end else begin
                check("done_cycle", 128'(cyc), 128'(done_exp_q.pop_front()));
                check("done_keys_valid", keys_valid, 1'b1);
            end
        end
    end

    task automatic load_key(input logic [127:0] k, input logic hold);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        done_exp_q.push_back(cyc + 10);
        if (!hold) key_valid = 1'b0;
    endtask

    task automatic wait_keys_valid();
        int n = 0;
        while (keys_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("keys_valid_timeout", keys_valid, 1'b1);
    endtask

    task automatic issue_read(input string name, input logic [3:0] idx, input logic [127:0] exp);
        @(negedge clk);
        rd_idx = idx;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        rd_req = 1'b1;
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Read round key n in schedule order, whatever the index mirroring.
    task automatic read_rk(input string name, input int n, input logic [127:0] exp);
`ifdef KEYEXP_INV_READ_EN
        issue_read(name, 4'(10 - n), exp);
`else
        issue_read(name, 4'(n), exp);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] e;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_key_ready", key_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_keys_valid", keys_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_key", rd_key, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 key, then full index sweep
        load_key(KeyFips, 1'b0);
        check("fips_busy", busy, 1'b1);
        check("fips_key_ready", key_ready, 1'b0);
        wait_keys_valid();
        for (int i = 0; i < 16; i++) begin
            if (i > 10) e = '0;
`ifdef KEYEXP_INV_READ_EN
            else e = FipsRk[10 - i];
`else
            else e = FipsRk[i];
`endif
            issue_read($sformatf("sweep_idx%0d", i), 4'(i), e);
        end
        end_reads();

        // Back-to-back load in DONE with the all-zero key
        load_key(KeyZero, 1'b0);
        check("b2b_keys_valid_drop", keys_valid, 1'b0);
        check("b2b_busy", busy, 1'b1);
        wait_keys_valid();
        read_rk("zero_rk0", 0, KeyZero);
        read_rk("zero_rk1", 1, ZeroRk1);
        read_rk("zero_rk10", 10, ZeroRk10);
        end_reads();

        // key_valid held through expansion with a different key
        load_key(KeyFips, 1'b1);
        key_in = 128'hdeadbeef_00112233_44556677_8899aabb;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold_key_ready%0d", k), key_ready, 1'b0);
            if (k == 9) key_valid = 1'b0;
        end
        wait_keys_valid();
        read_rk("hold_rk1", 1, FipsRk[1]);
        read_rk("hold_rk10", 10, FipsRk[10]);
        end_reads();

        // Reset in the middle of an expansion
        load_key(KeyZero, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        done_exp_q.delete();
        #1;
        check("midrst_rd_key", rd_key, 128'h0);
        check("midrst_keys_valid", keys_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_key_ready", key_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        read_rk("midrst_rk10_cleared", 10, 128'h0);
        end_reads();
        load_key(KeyFips, 1'b0);
        wait_keys_valid();
        read_rk("reload_rk10", 10, FipsRk[10]);
        read_rk("reload_rk5", 5, FipsRk[5]);
        end_reads();

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 128'(rd_exp_q.size()), 128'd0);
        check("done_queue_drained", 128'(done_exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
